// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I decode constants, ALU control encodings and the ID/EX bundle type.
package id_ex_stage_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  localparam logic [1:0] SRC1_REG  = 2'b00;
  localparam logic [1:0] SRC1_PC   = 2'b01;
  localparam logic [1:0] SRC1_ZERO = 2'b10;

  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_IMM  = 2'b01;
  localparam logic [1:0] SRC2_FOUR = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        mux_reg_wr;
    logic        jump;
    logic        branch;
    logic        jalr;
    logic [1:0]  ula_op;
    logic [1:0]  alu_src1;
    logic [1:0]  alu_src2;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
  } ex_bundle_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JALR: uses_rs1 = 1'b1;
      OP_LUI, OP_AUIPC, OP_JAL:                 uses_rs1 = 1'b0;
      default:                                  uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_S, OP_B: uses_rs2 = 1'b1;
      default:          uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection: a load in EX whose destination is a source of the ID instruction.
module id_ex_stage_hazard_unit
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [6:0] id_opcode_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_rd_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit    = uses_rs1(id_opcode_i) && (id_rs1_i == ex_rd_i);
    rs2_hit    = uses_rs2(id_opcode_i) && (id_rs2_i == ex_rd_i);
    load_use_o = id_valid_i && ex_valid_i && ex_mem_rd_i && (ex_rd_i != 5'd0) &&
                 (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion on stall/flush and a bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [6:0]  id_opcode,
  input  logic        id_mem_rd,
  input  logic        id_mem_wr,
  input  logic        id_reg_wr,
  input  logic        id_mux_reg_wr,
  input  logic        id_jump,
  input  logic        id_branch,
  input  logic        id_jalr,
  input  logic [1:0]  id_ula_op,
  input  logic [1:0]  id_alu_src1,
  input  logic [1:0]  id_alu_src2,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_val,
  input  logic [31:0] id_rs2_val,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [2:0]  id_funct3,
  input  logic        id_funct7b5,
  input  logic        flush_in,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic        ex_reg_wr,
  output logic        ex_mux_reg_wr,
  output logic        ex_jump,
  output logic        ex_branch,
  output logic        ex_jalr,
  output logic [1:0]  ex_ula_op,
  output logic [1:0]  ex_alu_src1,
  output logic [1:0]  ex_alu_src2,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic        ex_valid,
  output logic        stall_out,
  output logic [15:0] bubble_cnt
);

  ex_bundle_t  id_bundle;
  ex_bundle_t  ex_d, ex_q;
  logic [15:0] cnt_d, cnt_q;
  logic        load_use;

  id_ex_stage_hazard_unit u_hazard (
    .id_valid_i  (id_valid),
    .id_opcode_i (id_opcode),
    .id_rs1_i    (id_rs1),
    .id_rs2_i    (id_rs2),
    .ex_valid_i  (ex_q.valid),
    .ex_mem_rd_i (ex_q.mem_rd),
    .ex_rd_i     (ex_q.rd),
    .load_use_o  (load_use)
  );

  // A flush kills the ID instruction anyway, so holding PC/IF-ID for it would be wasted.
  assign stall_out = load_use && !flush_in;

  always_comb begin
    id_bundle = '{
      valid:      1'b1,
      mem_rd:     id_mem_rd,
      mem_wr:     id_mem_wr,
      reg_wr:     id_reg_wr,
      mux_reg_wr: id_mux_reg_wr,
      jump:       id_jump,
      branch:     id_branch,
      jalr:       id_jalr,
      ula_op:     id_ula_op,
      alu_src1:   id_alu_src1,
      alu_src2:   id_alu_src2,
      pc:         id_pc,
      rs1_val:    id_rs1_val,
      rs2_val:    id_rs2_val,
      imm:        id_imm,
      rs1:        id_rs1,
      rs2:        id_rs2,
      rd:         id_rd,
      funct3:     id_funct3,
      funct7b5:   id_funct7b5
    };

    ex_d = '0;
    if (!flush_in && !stall_out && id_valid) begin
      ex_d = id_bundle;
    end

    // Only hazard-driven bubbles are counted; an empty ID slot is not a bubble we inserted.
    cnt_d = cnt_q;
    if ((flush_in || stall_out) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_mem_rd     = ex_q.mem_rd;
  assign ex_mem_wr     = ex_q.mem_wr;
  assign ex_reg_wr     = ex_q.reg_wr;
  assign ex_mux_reg_wr = ex_q.mux_reg_wr;
  assign ex_jump       = ex_q.jump;
  assign ex_branch     = ex_q.branch;
  assign ex_jalr       = ex_q.jalr;
  assign ex_ula_op     = ex_q.ula_op;
  assign ex_alu_src1   = ex_q.alu_src1;
  assign ex_alu_src2   = ex_q.alu_src2;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_val    = ex_q.rs1_val;
  assign ex_rs2_val    = ex_q.rs2_val;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_funct3     = ex_q.funct3;
  assign ex_funct7b5   = ex_q.funct7b5;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus reset, full-capture and saturation sequences.
module tb_id_ex_stage;

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] I    = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] LUI  = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic        id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_jump, id_branch, id_jalr;
  logic [1:0]  id_ula_op, id_alu_src1, id_alu_src2;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        flush_in;
  logic        ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_jump, ex_branch, ex_jalr;
  logic [1:0]  ex_ula_op, ex_alu_src1, ex_alu_src2;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_valid;
  logic        stall_out;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_reg_wr(id_reg_wr),
    .id_mux_reg_wr(id_mux_reg_wr), .id_jump(id_jump), .id_branch(id_branch),
    .id_jalr(id_jalr), .id_ula_op(id_ula_op), .id_alu_src1(id_alu_src1),
    .id_alu_src2(id_alu_src2), .id_pc(id_pc), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .flush_in(flush_in), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_reg_wr(ex_reg_wr), .ex_mux_reg_wr(ex_mux_reg_wr), .ex_jump(ex_jump),
    .ex_branch(ex_branch), .ex_jalr(ex_jalr), .ex_ula_op(ex_ula_op),
    .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_valid(ex_valid), .stall_out(stall_out),
    .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        mrd;
    logic        rwr;
    logic [1:0]  uop;
    logic        fl;
    logic [31:0] pc;
    logic        e_stall;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic        e_mrd;
    logic        e_rwr;
    logic [1:0]  e_uop;
    logic [31:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic mrd,
                       input logic rwr, input logic [1:0] uop, input logic fl,
                       input logic [31:0] pc);
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_mem_rd = mrd; id_reg_wr = rwr; id_ula_op = uop; flush_in = fl; id_pc = pc;
    id_mem_wr = 1'b0; id_mux_reg_wr = mrd; id_jump = 1'b0; id_branch = 1'b0; id_jalr = 1'b0;
    id_alu_src1 = 2'b00; id_alu_src2 = 2'b00; id_rs1_val = 32'h0; id_rs2_val = 32'h0;
    id_imm = 32'h0; id_funct3 = 3'b000; id_funct7b5 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic mrd,
                              input logic rwr, input logic [1:0] uop, input logic fl,
                              input logic [31:0] pc, input logic es, input logic ev,
                              input logic [4:0] erd, input logic emrd, input logic erwr,
                              input logic [1:0] euop, input logic [31:0] epc,
                              input logic [15:0] ecnt);
    vec_t r;
    r.v = v; r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.mrd = mrd; r.rwr = rwr;
    r.uop = uop; r.fl = fl; r.pc = pc; r.e_stall = es; r.e_valid = ev; r.e_rd = erd;
    r.e_mrd = emrd; r.e_rwr = erwr; r.e_uop = euop; r.e_pc = epc; r.e_cnt = ecnt;
    return r;
  endfunction

  initial begin
    //              v  op   rs1 rs2 rd mrd rwr uop fl pc      | stall vld rd mrd rwr uop pc   cnt
    vecs[0]  = mk(1, R,   1, 2, 3, 0, 1, 2, 0, 32'h100, 0, 1, 3, 0, 1, 2, 32'h100, 0);
    vecs[1]  = mk(1, LD,  1, 0, 5, 1, 1, 0, 0, 32'h104, 0, 1, 5, 1, 1, 0, 32'h104, 0);
    vecs[2]  = mk(1, R,   5, 7, 6, 0, 1, 2, 0, 32'h108, 1, 0, 0, 0, 0, 0, 32'h0,   1);
    vecs[3]  = mk(1, R,   5, 7, 6, 0, 1, 2, 0, 32'h108, 0, 1, 6, 0, 1, 2, 32'h108, 1);
    vecs[4]  = mk(1, LD,  1, 0, 5, 1, 1, 0, 0, 32'h10c, 0, 1, 5, 1, 1, 0, 32'h10c, 1);
    vecs[5]  = mk(1, LUI, 5, 5, 5, 0, 1, 0, 0, 32'h110, 0, 1, 5, 0, 1, 0, 32'h110, 1);
    vecs[6]  = mk(1, LD,  1, 0, 0, 1, 1, 0, 0, 32'h114, 0, 1, 0, 1, 1, 0, 32'h114, 1);
    vecs[7]  = mk(1, R,   0, 0, 1, 0, 1, 2, 0, 32'h118, 0, 1, 1, 0, 1, 2, 32'h118, 1);
    vecs[8]  = mk(1, LD,  1, 0, 5, 1, 1, 0, 0, 32'h11c, 0, 1, 5, 1, 1, 0, 32'h11c, 1);
    vecs[9]  = mk(1, ST,  2, 5, 0, 0, 0, 0, 0, 32'h120, 1, 0, 0, 0, 0, 0, 32'h0,   2);
    vecs[10] = mk(1, ST,  2, 5, 0, 0, 0, 0, 0, 32'h120, 0, 1, 0, 0, 0, 0, 32'h120, 2);
    vecs[11] = mk(1, LD,  1, 0, 5, 1, 1, 0, 0, 32'h124, 0, 1, 5, 1, 1, 0, 32'h124, 2);
    vecs[12] = mk(1, R,   5, 5, 6, 0, 1, 2, 1, 32'h128, 0, 0, 0, 0, 0, 0, 32'h0,   3);
    vecs[13] = mk(0, R,   5, 5, 6, 0, 1, 2, 0, 32'h12c, 0, 0, 0, 0, 0, 0, 32'h0,   3);
    vecs[14] = mk(1, LD,  1, 0, 5, 1, 1, 0, 0, 32'h130, 0, 1, 5, 1, 1, 0, 32'h130, 3);
    vecs[15] = mk(1, LD,  5, 0, 7, 1, 1, 0, 0, 32'h134, 1, 0, 0, 0, 0, 0, 32'h0,   4);
    vecs[16] = mk(1, LD,  5, 0, 7, 1, 1, 0, 0, 32'h134, 0, 1, 7, 1, 1, 0, 32'h134, 4);
    vecs[17] = mk(1, I,   7, 3, 8, 0, 1, 0, 0, 32'h138, 1, 0, 0, 0, 0, 0, 32'h0,   5);
    vecs[18] = mk(0, I,   7, 3, 8, 0, 1, 0, 0, 32'h13c, 0, 0, 0, 0, 0, 0, 32'h0,   5);

    drive(0, 7'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    #12;
    check("reset_valid", {31'b0, ex_valid}, 32'h0);
    check("reset_stall", {31'b0, stall_out}, 32'h0);
    check("reset_cnt", {16'b0, bubble_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mrd,
            vecs[i].rwr, vecs[i].uop, vecs[i].fl, vecs[i].pc);
      #1;
      check($sformatf("v%0d_stall", i), {31'b0, stall_out}, {31'b0, vecs[i].e_stall});
      tick();
      check($sformatf("v%0d_ex", i),
            {ex_valid, ex_rd, ex_mem_rd, ex_reg_wr, ex_ula_op, bubble_cnt},
            {vecs[i].e_valid, vecs[i].e_rd, vecs[i].e_mrd, vecs[i].e_rwr, vecs[i].e_uop,
             vecs[i].e_cnt});
      check($sformatf("v%0d_pc", i), ex_pc, vecs[i].e_pc);
    end

    // Every field captured verbatim
    drive(1, I, 5'd17, 5'd22, 5'd9, 0, 1, 2'b10, 0, 32'hDEAD_BEE0);
    id_mem_wr = 1; id_mux_reg_wr = 1; id_jump = 1; id_branch = 1; id_jalr = 1;
    id_alu_src1 = 2'b01; id_alu_src2 = 2'b10; id_rs1_val = 32'h1234_5678;
    id_rs2_val = 32'h8765_4321; id_imm = 32'hFFFF_F800; id_funct3 = 3'b101; id_funct7b5 = 1;
    tick();
    check("cap_ctl", {25'b0, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_jump,
                      ex_branch, ex_jalr}, {25'b0, 7'b0111111});
    check("cap_fields", {20'b0, ex_ula_op, ex_alu_src1, ex_alu_src2, ex_funct3, ex_funct7b5,
                         ex_valid}, {20'b0, 2'b10, 2'b01, 2'b10, 3'b101, 1'b1, 1'b1});
    check("cap_idx", {17'b0, ex_rs1, ex_rs2, ex_rd}, {17'b0, 5'd17, 5'd22, 5'd9});
    check("cap_rs1_val", ex_rs1_val, 32'h1234_5678);
    check("cap_rs2_val", ex_rs2_val, 32'h8765_4321);
    check("cap_imm", ex_imm, 32'hFFFF_F800);
    check("cap_pc", ex_pc, 32'hDEAD_BEE0);

    // Asynchronous reset mid-cycle while ex_reg_wr is high
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ex", {ex_valid, ex_reg_wr, ex_mem_wr, ex_jump, ex_rd, ex_funct3},
          32'h0);
    check("async_rst_data", ex_rs1_val | ex_rs2_val | ex_imm | ex_pc, 32'h0);
    check("async_rst_misc", {15'b0, stall_out, bubble_cnt}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(1, R, 1, 2, 3, 0, 1, 2'b10, 0, 32'h200);
    tick();
    check("post_rst_first", {ex_valid, ex_reg_wr, ex_rd, ex_ula_op}, {23'b0, 1'b1, 1'b1,
          5'd3, 2'b10});

    // Saturation: drive flushes until the counter reaches FFFE, then three more
    drive(1, R, 1, 2, 3, 0, 1, 2'b10, 1, 32'h204);
    for (int n = 0; n < 65534; n++) begin
      @(posedge clk);
    end
    #1;
    check("cnt_fffe", {16'b0, bubble_cnt}, 32'h0000_FFFE);
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("cnt_sat%0d", n), {16'b0, bubble_cnt}, 32'h0000_FFFF);
    end
    check("sat_bubble", {31'b0, ex_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection and bubble insertion for the RV32I five-stage pipeline. Captures the decode-stage control bundle and operands every cycle and presents them to EX. It detects a load in EX whose destination is read by the instruction in ID, then stalls PC and IF/ID while injecting a bubble. A taken branch or jump resolved in EX squashes the ID instruction.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_opcode  in  7  opcode of the ID instruction, used for source-use decode
- id_mem_rd, id_mem_wr, id_reg_wr, id_mux_reg_wr, id_jump, id_branch, id_jalr  in  1 each  control bits from decode
- id_ula_op, id_alu_src1, id_alu_src2  in  2 each  control fields from decode
- id_pc, id_rs1_val, id_rs2_val, id_imm  in  32 each  operands
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct3  in  3; id_funct7b5  in  1  ALU qualifiers
- flush_in  in  1  EX resolved taken branch/jump this cycle
- ex_* outputs  out  same widths  registered copies of every id_* input except id_opcode
- ex_valid  out  1  EX slot holds a real instruction
- stall_out  out  1  hold PC and IF/ID this cycle, combinational
- bubble_cnt  out  16  saturating count of inserted bubbles

## Operation
- Source-use decode from id_opcode:
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - Neither is used for LUI, AUIPC, JAL, or unknown opcodes.
- load_use = id_valid & ex_valid & ex_mem_rd & (ex_rd != 0) & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)).
- stall_out = load_use & ~flush_in.
- Each rising edge, the action is chosen by priority:
  - flush_in = 1: load a bubble.
  - stall_out = 1: load a bubble.
  - id_valid = 0: load a bubble.
  - Otherwise: capture every id_* field and set ex_valid = 1.
- A bubble sets all ex_ control bits, 2-bit fields, data fields, and indices to 0, and sets ex_valid = 0.
- bubble_cnt increments by 1 on an edge where the flush or the stall path loads the bubble. It does not increment when the bubble comes from id_valid = 0. It saturates at 16'hFFFF.

## Timing
- Reset, asynchronous, takes effect immediately: every ex_* output, ex_valid, and bubble_cnt go to 0. stall_out evaluates to 0 because ex_valid = 0.
- Latency is 1 cycle from id_* to ex_*.
- stall_out is valid in the same cycle as its inputs. It must settle before the edge at which PC and IF/ID sample it.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_rd = 0, so the held ID instruction advances on the next edge.
- Simultaneous flush_in and load_use: stall_out = 0, one bubble, counter +1.
- Reset deasserted mid-stream: the first edge after release behaves normally from the ID inputs.
- A load writing x0 never stalls.
- A back-to-back load followed by a dependent load stalls once.

## Structure
- Shared package holds:
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR).
  - ula_op encodings: 00 add, 10 funct-decoded.
  - alu_src1 encodings: 00 reg, 01 pc, 10 zero.
  - alu_src2 encodings: 00 reg, 01 imm, 10 four.
- One combinational sub-module, hazard_unit: opcode source-use decode plus the load_use compare. The register bank and counter stay in id_ex_stage.

## Test plan
- Reset asserted mid-cycle with ex_reg_wr = 1 → all outputs 0 immediately, without waiting for a clock edge.
- ADD x3,x1,x2 in ID (id_valid = 1) → next edge ex_reg_wr = 1, ex_ula_op = 10, ex_rd = 3, ex_valid = 1, stall_out = 0.
- LW x5 in EX, then ADD x6,x5,x7 in ID → stall_out = 1 for one cycle, bubble loaded, bubble_cnt = 1. The ADD reaches EX on the following edge.
- LW x5 in EX, then LUI x5 in ID → stall_out = 0. LW x0 in EX, then ADD x1,x0,x0 in ID → stall_out = 0.
- LW x5 in EX, ADD x6,x5,x5 in ID, flush_in = 1 → stall_out = 0, bubble loaded, bubble_cnt increments by exactly 1.
- Force bubble_cnt to 16'hFFFE, then apply three flushes → the count holds at 16'hFFFF.
